merge_n: RTL
============

// Module: merge_n
// PURPOSE
//  N-way controlled merge. Each token on select channel C chooses one of N data
//  inputs. Exactly one token is moved from that input to R; the other inputs are untouched.
//  Successor of the 2-way merge:
//  - generalised input count and data width
//  - DEPTH-entry output FIFO
//  - ready asserted only on the input actually consumed
//  - defined handling of out-of-range selects
//  Sits between a control-token source and a datapath consumer in the flow pipeline.
// PARAMETERS
//  WIDTH  64  data bits per token
//  N      2   number of data inputs (>=2)
//  SEL_W  $clog2(N)  select width (derived; >=1)
//  DEPTH  2   output FIFO entries (>=1, any integer)
// PORTS
//  clk      in   1          clock; all logic on posedge
//  reset    in   1          synchronous, active-low reset (0 = reset)
//  In_data  in   N*WIDTH    input i occupies bits [i*WIDTH +: WIDTH]
//  In_valid in   N          per-input valid
//  In_ready out  N          per-input ready
//  C_data   in   SEL_W      select value
//  C_valid  in   1          select valid
//  C_ready  out  1          select ready
//  R_data   out  WIDTH      FIFO head data
//  R_valid  out  1          FIFO non-empty
//  R_ready  in   1          consumer ready
//  R_count  out  $clog2(DEPTH+1)  current FIFO occupancy
//  err      out  1          sticky flag: out-of-range select seen
// BEHAVIOUR
//  Reset (reset==0 at posedge): count=0, rd/wr ptrs=0, R_valid=0, R_data=0, err=0.
//   Buffered tokens are discarded. Reset overrides any same-cycle handshake.
//  space    = (count < DEPTH) || (R_valid && R_ready)
//   Pop and push in the same cycle are allowed when the FIFO is full.
//  good     = C_valid && (C_data < N) && In_valid[C_data]
//  fire     = good && space
//  bad      = C_valid && (C_data >= N)
//  C_ready  = fire || bad
//  In_ready[i] = fire && (C_data == i); all other In_ready bits are 0.
//  Handshake rules:
//   - Input i completes only together with C.
//   - C never completes on a valid select whose data input is not valid.
//   - No input is consumed when C_valid=0.
//  Bad select: the C token is consumed and dropped, no In_ready is asserted,
//   nothing is pushed, and err goes to 1 on the next edge. err is cleared only by reset.
//  Push on fire: In_data[C_data] is written at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
//  Pop when R_valid && R_ready: rd_ptr advances with the same wrap rule.
//  count += push - pop.
//  Latency: a token accepted at edge k appears on R_valid/R_data after edge k
//   (1 cycle). There is no combinational path from any In_* input to R_*.
//  Empty FIFO: R_valid=0 and R_data holds the last popped value (0 after reset);
//   no bypass. Push into an empty FIFO is visible next cycle.
//  Ordering: strictly FIFO, preserving C-token order.
//  R_data/R_valid remain stable while R_valid && !R_ready.
//  The outputs are combinational only from registered state plus the In/C/R_ready inputs.
//  In_ready and C_ready may depend on the valid inputs; valid inputs never
//   depend on ready.
// TESTING
//  T1 N=4,DEPTH=2: C=2,In2=0xAA, R_ready=1 -> In_ready=0100, C_ready=1;
//     next cycle R_valid=1, R_data=0xAA, R_count=1.
//  T2 C=1 valid, In1_valid=0, In0/In3 valid -> C_ready=0, In_ready=0000 for 5
//     cycles; raise In1 -> single transfer of In1 only.
//  T3 R_ready=0, push 0x1,0x2 -> R_count=2, C_ready=0 on third token. Then R_ready=1
//     -> pop 0x1 and push 0x3 in the same cycle; output order 1,2,3.
//  T4 N=3: C_data=3 -> C_ready=1, In_ready=000, no push, err=1 next cycle and stays
//     1; following C=0 token merges normally.
//  T5 DEPTH=3: 10 random tokens with random R_ready -> pointers wrap and the scoreboard
//     matches the selected-input order exactly.
//  T6 Two tokens buffered, drive reset=0 for 1 cycle while a fire is pending ->
//     R_valid=0, R_count=0, err=0, and the pending input is not acknowledged.

Source files
------------

// File: rtl/merge_n_if.sv
// merge_n_if: handshake bundle for the N-way controlled merge.
//   In_*  : N data inputs, input i at In_data[i*WIDTH +: WIDTH]
//   C_*   : select token channel
//   R_*   : merged output (FIFO head), R_count = occupancy
//   err   : sticky out-of-range select flag
// master = token source / consumer side, slave = merge block.
interface merge_n_if #(
    parameter int WIDTH = 64,
    parameter int N     = 2,
    parameter int DEPTH = 2,
    parameter int SEL_W = $clog2(N),
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic [N*WIDTH-1:0] In_data;
    logic [N-1:0]       In_valid;
    logic [N-1:0]       In_ready;
    logic [SEL_W-1:0]   C_data;
    logic               C_valid;
    logic               C_ready;
    logic [WIDTH-1:0]   R_data;
    logic               R_valid;
    logic               R_ready;
    logic [CNT_W-1:0]   R_count;
    logic               err;

    modport master (
        output In_data, In_valid, C_data, C_valid, R_ready,
        input  In_ready, C_ready, R_data, R_valid, R_count, err
    );

    modport slave (
        input  In_data, In_valid, C_data, C_valid, R_ready,
        output In_ready, C_ready, R_data, R_valid, R_count, err
    );
endinterface

// File: rtl/merge_n.sv
// merge_n: N-way controlled merge into a DEPTH-entry output FIFO.
// Each C token selects one data input; that single input is moved into the
// FIFO together with the C token. Out-of-range selects are consumed, dropped
// and latched into the sticky err flag.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-low reset
//   bus   : merge_n_if.slave (In_*, C_*, R_*, R_count, err)
module merge_n #(
    parameter int WIDTH = 64,
    parameter int N     = 2,
    parameter int DEPTH = 2
) (
    input logic        clk,
    input logic        reset,
    merge_n_if.slave   bus
);
    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             err_q, err_d;

    logic [N-1:0]     sel_oh;
    logic [WIDTH-1:0] push_data;
    logic             r_valid, pop, space, good, fire, bad;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // One-hot decode of the select; an out-of-range select decodes to all
    // zeros, which keeps it from ever matching a data input.
    always_comb begin
        sel_oh    = '0;
        push_data = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.C_data == SEL_W'(i)) begin
                sel_oh[i] = 1'b1;
                push_data = bus.In_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        r_valid = (count_q != '0);
        pop     = r_valid && bus.R_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        space   = (count_q < DEPTH_C) || pop;
        good    = bus.C_valid && |(sel_oh & bus.In_valid);
        // Handshakes are suppressed while reset is held so nothing is
        // acknowledged that the reset would then discard.
        fire    = reset && good && space;
        bad     = reset && bus.C_valid && (sel_oh == '0);

        wr_ptr_d = fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(fire) - CNT_W'(pop);
        // Empty FIFO presents the most recently popped word.
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
        err_d    = err_q || bad;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (fire) mem_q[wr_ptr_q] <= push_data;
    end

    assign bus.R_valid  = r_valid;
    assign bus.R_data   = r_valid ? mem_q[rd_ptr_q] : last_q;
    assign bus.R_count  = count_q;
    assign bus.err      = err_q;
    assign bus.C_ready  = fire || bad;
    assign bus.In_ready = fire ? sel_oh : '0;
endmodule
